down_counter8: RTL and testbench

Loadable, cascadable 8-bit down counter with auto-reload, the decrementing counterpart to the team's 8-bit up counter. It is built from two 4-bit down-counting nibble slices joined by a borrow chain, and keeps the same ENP/ENT/RCO cascading semantics so it can be chained with other counter slices. Its main job is to act as a programmable clock divider and interval timer. With auto-reload on, RCO fires once every (R+1) enabled cycles, where R is the loaded reload value.

---
 rtl/down_counter8.sv | 64 ++++++
 tb/tb_down_counter8.sv | 121 ++++++++++++
 2 files changed

// File: rtl/down_counter8.sv
// Loadable 8-bit down counter with auto-reload, built from two 4-bit slices
// joined by a borrow chain; RCO cascades like the matching up counter.
module down_counter8 (
    input  logic       CLK,
    input  logic       nRST,
    input  logic       nCLR,
    input  logic       nLOAD,
    input  logic       ENP,
    input  logic       ENT,
    input  logic       AUTO,
    input  logic [7:0] Din,
    output logic [7:0] Dout,
    output logic       RCO
);

    logic [7:0] cnt_q, cnt_d;
    logic [7:0] rld_q, rld_d;
    logic [7:0] dec_val;
    logic [1:0] nib_en;
    logic       borrow_lo;

    assign borrow_lo = ENT & (cnt_q[3:0] == 4'h0);
    assign nib_en[0] = ENP & ENT;
    assign nib_en[1] = ENP & borrow_lo;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_nib
            assign dec_val[gi*4 +: 4] = nib_en[gi] ? (cnt_q[gi*4 +: 4] - 4'd1)
                                                   : cnt_q[gi*4 +: 4];
        end
    endgenerate

    always_comb begin
        cnt_d = cnt_q;
        rld_d = rld_q;
        if (!nCLR) begin
            cnt_d = 8'h00;
        end else if (!nLOAD) begin
            cnt_d = Din;
            rld_d = Din;
        end else if (ENP && ENT) begin
            // Terminal count overrides the slice borrow chain for both nibbles at once.
            if (cnt_q == 8'h00)
                cnt_d = AUTO ? rld_q : 8'hFF;
            else
                cnt_d = dec_val;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= 8'h00;
            rld_q <= 8'h00;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
        end
    end

    assign Dout = cnt_q;
    assign RCO  = ENT & (cnt_q == 8'h00);

endmodule

// File: tb/tb_down_counter8.sv
// Bench for down_counter8: directed scenarios plus random stimulus checked
// against an arithmetic reference model of count and reload value.
module tb_down_counter8;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       nCLR = 1'b1;
    logic       nLOAD = 1'b1;
    logic       ENP = 1'b0;
    logic       ENT = 1'b1;
    logic       AUTO = 1'b0;
    logic [7:0] Din = 8'h00;
    logic [7:0] Dout;
    logic       RCO;

    int n_checks = 0;
    int n_errors = 0;
    int m_cnt = 0;
    int m_rld = 0;
    int rco_hits;

    down_counter8 dut (
        .CLK(CLK), .nRST(nRST), .nCLR(nCLR), .nLOAD(nLOAD), .ENP(ENP),
        .ENT(ENT), .AUTO(AUTO), .Din(Din), .Dout(Dout), .RCO(RCO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock transaction: drive inputs mid-cycle, then compare after the edge.
    task automatic step(input logic nclr, input logic nload, input logic enp,
                        input logic ent, input logic auto_v, input logic [7:0] din);
        @(negedge CLK);
        nCLR = nclr; nLOAD = nload; ENP = enp; ENT = ent; AUTO = auto_v; Din = din;
        #1 check("rco_pre", {7'd0, RCO}, {7'd0, (ent && m_cnt == 0)});
        @(posedge CLK);
        if (!nclr)            m_cnt = 0;
        else if (!nload)      begin m_cnt = din; m_rld = din; end
        else if (enp && ent)  m_cnt = (m_cnt == 0) ? (auto_v ? m_rld : 255) : m_cnt - 1;
        #1;
        check("dout", Dout, m_cnt[7:0]);
        check("rco", {7'd0, RCO}, {7'd0, (ent && m_cnt == 0)});
        $display("txn clr=%b ld=%b enp=%b ent=%b auto=%b din=%h -> dout=%h rco=%b",
                 nclr, nload, enp, ent, auto_v, din, Dout, RCO);
    endtask

    initial begin
        // Reset asserted from time zero with ENT=1.
        #2;
        check("rst_dout", Dout, 8'h00);
        check("rst_rco", {7'd0, RCO}, 8'h01);
        @(negedge CLK);
        nRST = 1'b1;

        // Free run from reset with AUTO=0 wraps to FF.
        repeat (3) step(1, 1, 1, 1, 0, 8'h00);

        // Nibble borrow.
        step(1, 0, 0, 0, 0, 8'h10);
        repeat (2) step(1, 1, 1, 1, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h01);
        repeat (2) step(1, 1, 1, 1, 0, 8'h00);

        // Divider with R=3: RCO high once every four cycles.
        step(1, 0, 1, 1, 1, 8'h03);
        rco_hits = 0;
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 1, 1, 1, 8'h00);
            if (RCO) rco_hits++;
        end
        check("div4_rco_hits", rco_hits[7:0], 8'd3);
        step(1, 0, 1, 1, 1, 8'h00);
        repeat (4) step(1, 1, 1, 1, 1, 8'h00);

        // Enables.
        step(1, 0, 0, 0, 0, 8'h05);
        repeat (3) step(1, 1, 0, 1, 0, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 1, 1, 0, 0, 8'h00);
        step(1, 1, 0, 1, 0, 8'h00);

        // Priority: clear beats load and leaves the reload value intact.
        step(1, 0, 0, 0, 1, 8'h33);
        step(1, 1, 1, 1, 1, 8'h00);
        step(0, 0, 1, 1, 1, 8'hA5);
        step(1, 1, 1, 1, 1, 8'h00);
        check("reload_old_rld", Dout, 8'h33);
        step(1, 1, 1, 1, 1, 8'h00);
        step(1, 0, 0, 0, 0, 8'h00);
        step(1, 0, 1, 1, 1, 8'h42);

        // Async reset mid-count discards the reload value.
        step(1, 0, 0, 0, 1, 8'h07);
        repeat (3) step(1, 1, 1, 1, 1, 8'h00);
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1 check("async_rst", Dout, 8'h00);
        m_cnt = 0; m_rld = 0;
        #1 nRST = 1'b1;
        repeat (2) step(1, 1, 1, 1, 1, 8'h00);

        // Random traffic, biased toward small reload values.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
                 $urandom_range(0, 1),
                 ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 7)) : 8'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
